// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem over req/rdy and loads IF/ID.
// Optional halt-opcode support is enabled by defining FETCH_HALT_EN.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_cur,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetchState_t;

`ifdef FETCH_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    fetchState_t r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ifidInstr;
    logic [15:0] r_ifidPcPlus2;
    logic        r_ifidValid;
    logic [15:0] r_skid;

    fetchState_t w_stateNext;
    logic [15:0] w_pcNext;
    logic [15:0] w_ifidInstrNext;
    logic [15:0] w_ifidPcPlus2Next;
    logic        w_ifidValidNext;
    logic [15:0] w_skidNext;
    logic [15:0] w_pcPlus2;
    logic [15:0] w_acceptData;
    logic        w_acceptHalt;

    assign w_pcPlus2    = r_pc + 16'd2;
    // An instruction is accepted either straight from imem or from the skid register.
    assign w_acceptData = (r_state == HOLD) ? r_skid : imem_data;
    assign w_acceptHalt = HALT_EN && (w_acceptData[15:12] == HALT_OPCODE);

    always_comb begin
        w_stateNext       = r_state;
        w_pcNext          = r_pc;
        w_ifidInstrNext   = r_ifidInstr;
        w_ifidPcPlus2Next = r_ifidPcPlus2;
        w_ifidValidNext   = r_ifidValid;
        w_skidNext        = r_skid;
        case (r_state)
            FETCH: begin
                if (redirect) begin
                    // A request still in flight must complete before fetching the target.
                    w_pcNext        = redirect_pc;
                    w_ifidValidNext = 1'b0;
                    if (!imem_rdy) begin
                        w_stateNext = DRAIN;
                    end
                end else if (imem_rdy) begin
                    if (stall) begin
                        w_skidNext  = imem_data;
                        w_stateNext = HOLD;
                    end else begin
                        w_ifidInstrNext   = w_acceptData;
                        w_ifidPcPlus2Next = w_pcPlus2;
                        w_ifidValidNext   = 1'b1;
                        if (w_acceptHalt) begin
                            w_stateNext = HALT;
                        end else begin
                            w_pcNext = w_pcPlus2;
                        end
                    end
                end else if (!stall) begin
                    w_ifidValidNext = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_pcNext        = redirect_pc;
                    w_ifidValidNext = 1'b0;
                    w_stateNext     = FETCH;
                end else if (!stall) begin
                    w_ifidInstrNext   = w_acceptData;
                    w_ifidPcPlus2Next = w_pcPlus2;
                    w_ifidValidNext   = 1'b1;
                    if (w_acceptHalt) begin
                        w_stateNext = HALT;
                    end else begin
                        w_pcNext    = w_pcPlus2;
                        w_stateNext = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    w_pcNext        = redirect_pc;
                    w_ifidValidNext = 1'b0;
                end else if (!stall) begin
                    w_ifidValidNext = 1'b0;
                end
                if (imem_rdy) begin
                    w_stateNext = FETCH;
                end
            end
            HALT: begin
                if (redirect) begin
                    w_pcNext        = redirect_pc;
                    w_ifidValidNext = 1'b0;
                    w_stateNext     = FETCH;
                end else if (!stall) begin
                    w_ifidValidNext = 1'b0;
                end
            end
            default: begin
                w_stateNext = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_ifidInstr   <= 16'h0000;
            r_ifidPcPlus2 <= 16'h0000;
            r_ifidValid   <= 1'b0;
            r_skid        <= 16'h0000;
        end else begin
            r_state       <= w_stateNext;
            r_pc          <= w_pcNext;
            r_ifidInstr   <= w_ifidInstrNext;
            r_ifidPcPlus2 <= w_ifidPcPlus2Next;
            r_ifidValid   <= w_ifidValidNext;
            r_skid        <= w_skidNext;
        end
    end

    assign imem_req      = (r_state == FETCH) || (r_state == DRAIN);
    assign imem_addr     = r_pc;
    assign pc_cur        = r_pc;
    assign ifid_instr    = r_ifidInstr;
    assign ifid_pc_plus2 = r_ifidPcPlus2;
    assign ifid_valid    = r_ifidValid;

`ifdef FETCH_HALT_EN
    assign halted = (r_state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
